// File: rtl/out_pingpong_buffer_if.sv
// Stream bundle for the multi-bank output buffer: producer side, consumer side
// and the status outputs used by the controller for credit accounting.
interface out_pingpong_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 2
);
    localparam int CW = $clog2(NUM_BANKS + 1);

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;
    logic                  word_sent;
    logic [CW-1:0]         banks_full;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, word_sent, banks_full
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, word_sent, banks_full
    );
endinterface

// File: rtl/out_pingpong_buffer.sv
// N-bank round-robin output buffer: banks fill from the core stream, close on a
// full bank or in_last, and drain in order with a registered output stage.
module out_pingpong_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int NUM_BANKS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    out_pingpong_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(NUM_BANKS + 1);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    bank_state_e           state_q [NUM_BANKS];
    bank_state_e           state_d [NUM_BANKS];
    logic [AW-1:0]         lenm1_q [NUM_BANKS];   // stored as len-1
    logic [AW-1:0]         lenm1_d [NUM_BANKS];
    logic                  last_q  [NUM_BANKS];
    logic                  last_d  [NUM_BANKS];
    logic [DATA_WIDTH-1:0] mem_q   [NUM_BANKS][DEPTH];

    logic [BW-1:0]         wb_q, wb_d, rb_q, rb_d;
    logic [AW-1:0]         wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  word_sent_q, word_sent_d;
    logic [CW-1:0]         banks_full_q, banks_full_d;
    logic                  write_s, close_s, pop_s, free_s;

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        if (b == BW'(NUM_BANKS - 1)) begin
            return '0;
        end else begin
            return b + 1'b1;
        end
    endfunction

    // Bank bookkeeping, pointers, output stage and occupancy count.
    always_comb begin
        state_d      = state_q;
        lenm1_d      = lenm1_q;
        last_d       = last_q;
        wb_d         = wb_q;
        wcnt_d       = wcnt_q;
        rb_d         = rb_q;
        rcnt_d       = rcnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        banks_full_d = banks_full_q;

        write_s = bus.in_valid && (state_q[wb_q] != BANK_FULL);
        close_s = write_s && ((wcnt_q == AW'(DEPTH - 1)) || bus.in_last);
        pop_s   = (state_q[rb_q] == BANK_FULL) && (!out_valid_q || bus.out_ready);
        free_s  = pop_s && (rcnt_q == lenm1_q[rb_q]);
        word_sent_d = out_valid_q && bus.out_ready;

        if (write_s) begin
            if (close_s) begin
                state_d[wb_q] = BANK_FULL;
                lenm1_d[wb_q] = wcnt_q;
                last_d[wb_q]  = bus.in_last;
                wcnt_d        = '0;
                wb_d          = next_bank(wb_q);
            end else begin
                state_d[wb_q] = BANK_FILLING;
                wcnt_d        = wcnt_q + 1'b1;
            end
        end else begin
            wcnt_d = wcnt_q;
        end

        if (pop_s) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rb_q][rcnt_q];
            out_last_d  = last_q[rb_q] && (rcnt_q == lenm1_q[rb_q]);
            if (free_s) begin
                state_d[rb_q] = BANK_EMPTY;
                rcnt_d        = '0;
                rb_d          = next_bank(rb_q);
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case ({close_s, free_s})
            2'b10:   banks_full_d = banks_full_q + 1'b1;
            2'b01:   banks_full_d = banks_full_q - 1'b1;
            default: banks_full_d = banks_full_q;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= '{default: BANK_EMPTY};
            lenm1_q      <= '{default: '0};
            last_q       <= '{default: 1'b0};
            wb_q         <= '0;
            wcnt_q       <= '0;
            rb_q         <= '0;
            rcnt_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            word_sent_q  <= 1'b0;
            banks_full_q <= '0;
        end else begin
            state_q      <= state_d;
            lenm1_q      <= lenm1_d;
            last_q       <= last_d;
            wb_q         <= wb_d;
            wcnt_q       <= wcnt_d;
            rb_q         <= rb_d;
            rcnt_q       <= rcnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            word_sent_q  <= word_sent_d;
            banks_full_q <= banks_full_d;
        end
    end

    // Bank storage; contents are don't-care until a bank is closed.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_q[wb_q][wcnt_q] <= bus.in_data;
        end
    end

    assign bus.in_ready   = (state_q[wb_q] != BANK_FULL);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.word_sent  = word_sent_q;
    assign bus.banks_full = banks_full_q;
endmodule

// File: tb/tb_out_pingpong_buffer.sv
// Directed bench for out_pingpong_buffer: cycle vector table plus streaming,
// backpressure, mid-frame reset and a three-bank randomised run.
module tb_out_pingpong_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2 = 1'b1;
    logic rst3 = 1'b1;

    out_pingpong_buffer_if #(.DATA_WIDTH(32), .NUM_BANKS(2)) b2();
    out_pingpong_buffer_if #(.DATA_WIDTH(16), .NUM_BANKS(3)) b3();

    out_pingpong_buffer #(.DATA_WIDTH(32), .DEPTH(16), .NUM_BANKS(2)) u2 (
        .clk(clk), .rst(rst2), .bus(b2)
    );
    out_pingpong_buffer #(.DATA_WIDTH(16), .DEPTH(4), .NUM_BANKS(3)) u3 (
        .clk(clk), .rst(rst3), .bus(b3)
    );

    typedef struct packed {
        logic        iv;
        logic [31:0] id;
        logic        il;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ol;
        logic        e_ws;
        logic [1:0]  e_bf;
    } vec_t;

    vec_t        vt [21];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic [32:0] q2 [$];
    logic [16:0] q3 [$];
    bit          mon2 = 1'b0, mon3 = 1'b0, gapchk = 1'b0, first_seen = 1'b0, run3 = 1'b0;
    int          hs2 = 0, ws2 = 0, gaps = 0, first_cyc = 0, hs3 = 0, ws3 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor for the two-bank instance.
    initial forever begin
        @(negedge clk);
        if (mon2 && !rst2) begin
            if (b2.word_sent) ws2++;
            if (gapchk && first_seen && !b2.out_valid && q2.size() > 0) gaps++;
            if (b2.out_valid && !first_seen) begin
                first_seen = 1'b1;
                first_cyc  = cyc;
            end
            if (b2.out_valid && b2.out_ready) begin
                hs2++;
                if (q2.size() == 0) chk("out2_unexpected", 64'd1, 64'd0);
                else chk("out2_word", {b2.out_last, b2.out_data}, q2.pop_front());
            end
        end
    end

    // Scoreboard monitor for the three-bank instance.
    initial forever begin
        @(negedge clk);
        if (mon3 && !rst3) begin
            if (b3.word_sent) ws3++;
            if (b3.out_valid && b3.out_ready) begin
                hs3++;
                if (q3.size() == 0) chk("out3_unexpected", 64'd1, 64'd0);
                else chk("out3_word", {b3.out_last, b3.out_data}, q3.pop_front());
            end
        end
    end

    task automatic reset2();
        @(posedge clk); #1;
        rst2 = 1'b1;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b0;
        q2.delete();
    endtask

    task automatic push2(input logic [31:0] d, input logic l);
        int t = 0;
        b2.in_valid = 1'b1; b2.in_data = d; b2.in_last = l;
        @(negedge clk);
        while (!b2.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!b2.in_ready) chk("push2_timeout", 64'd0, 64'd1);
        else begin
            last_acc = cyc;
            q2.push_back({l, d});
        end
        @(posedge clk); #1;
        b2.in_valid = 1'b0; b2.in_last = 1'b0;
    endtask

    task automatic push3(input logic [15:0] d, input logic l);
        int t = 0;
        b3.in_valid = 1'b1; b3.in_data = d; b3.in_last = l;
        @(negedge clk);
        while (!b3.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!b3.in_ready) chk("push3_timeout", 64'd0, 64'd1);
        else q3.push_back({l, d});
        @(posedge clk); #1;
        b3.in_valid = 1'b0; b3.in_last = 1'b0;
    endtask

    task automatic drain2(input string nm);
        int t = 0;
        while (q2.size() > 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(nm, 64'(q2.size()), 64'd0);
    endtask

    initial begin
        logic ir14, ir15;
        int   t;

        b2.in_valid = 1'b0; b2.in_data = '0; b2.in_last = 1'b0; b2.out_ready = 1'b1;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.in_last = 1'b0; b3.out_ready = 1'b1;

        // iv id il ordy | in_ready out_valid out_data out_last word_sent banks_full
        vt[0]  = '{1'b1, 32'd100, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,   1'b0, 1'b0, 2'd0};
        vt[1]  = '{1'b1, 32'd101, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,   1'b0, 1'b0, 2'd0};
        vt[2]  = '{1'b1, 32'd102, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,   1'b0, 1'b0, 2'd0};
        vt[3]  = '{1'b1, 32'd103, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,   1'b0, 1'b0, 2'd0};
        vt[4]  = '{1'b1, 32'd104, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0,   1'b0, 1'b0, 2'd0};
        vt[5]  = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b0, 32'd0,   1'b0, 1'b0, 2'd1};
        vt[6]  = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b1, 32'd100, 1'b0, 1'b0, 2'd1};
        vt[7]  = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b1, 32'd101, 1'b0, 1'b1, 2'd1};
        vt[8]  = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b1, 32'd102, 1'b0, 1'b1, 2'd1};
        vt[9]  = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b1, 32'd103, 1'b0, 1'b1, 2'd1};
        vt[10] = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b1, 32'd104, 1'b1, 1'b1, 2'd0};
        vt[11] = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b0, 32'd104, 1'b0, 1'b1, 2'd0};
        vt[12] = '{1'b1, 32'd200, 1'b0, 1'b1, 1'b1, 1'b0, 32'd104, 1'b0, 1'b0, 2'd0};
        vt[13] = '{1'b1, 32'd201, 1'b1, 1'b1, 1'b1, 1'b0, 32'd104, 1'b0, 1'b0, 2'd0};
        vt[14] = '{1'b0, 32'd0,   1'b0, 1'b0, 1'b1, 1'b0, 32'd104, 1'b0, 1'b0, 2'd1};
        vt[15] = '{1'b0, 32'd0,   1'b0, 1'b0, 1'b1, 1'b1, 32'd200, 1'b0, 1'b0, 2'd1};
        vt[16] = '{1'b0, 32'd0,   1'b0, 1'b0, 1'b1, 1'b1, 32'd200, 1'b0, 1'b0, 2'd1};
        vt[17] = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b1, 32'd200, 1'b0, 1'b0, 2'd1};
        vt[18] = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b1, 32'd201, 1'b1, 1'b1, 2'd0};
        vt[19] = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b0, 32'd201, 1'b0, 1'b1, 2'd0};
        vt[20] = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b0, 32'd201, 1'b0, 1'b0, 2'd0};

        // Short frames and output stalls, cycle by cycle from reset.
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b0;
        for (int i = 0; i < 21; i++) begin
            b2.in_valid = vt[i].iv; b2.in_data = vt[i].id;
            b2.in_last = vt[i].il;  b2.out_ready = vt[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {b2.in_ready, b2.out_valid, b2.out_data, b2.out_last, b2.word_sent, b2.banks_full},
                {vt[i].e_irdy, vt[i].e_ov, vt[i].e_od, vt[i].e_ol, vt[i].e_ws, vt[i].e_bf});
            @(posedge clk); #1;
        end

        // Streaming 64 words through two full-depth banks.
        reset2();
        b2.out_ready = 1'b1;
        mon2 = 1'b1; gapchk = 1'b1; first_seen = 1'b0; gaps = 0; ws2 = 0; first_cyc = 0;
        t = 0;
        for (int i = 0; i < 64; i++) begin
            push2(32'(i), (i == 63));
            if (i == 15) t = last_acc;
        end
        drain2("stream_drain");
        chk("stream_first_latency", 64'(first_cyc - t), 64'd2);
        chk("stream_gaps", 64'(gaps), 64'd0);
        chk("stream_word_sent", 64'(ws2), 64'd64);
        gapchk = 1'b0;

        // Backpressure: fill both banks with the output stalled.
        reset2();
        b2.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) push2(32'(i), 1'b0);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(b2.in_ready), 64'd0);
        chk("bp_banks_full", 64'(b2.banks_full), 64'd2);
        chk("bp_head_word", {b2.out_valid, b2.out_data}, {1'b1, 32'd0});
        repeat (3) @(negedge clk);
        chk("bp_hold", {b2.out_valid, b2.out_last, b2.out_data}, {1'b1, 1'b0, 32'd0});
        @(posedge clk); #1;
        b2.out_ready = 1'b1;
        ir14 = 1'b1; ir15 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 14) ir14 = b2.in_ready;
            if (k == 15) ir15 = b2.in_ready;
        end
        chk("bp_in_ready_before_free", 64'(ir14), 64'd0);
        chk("bp_in_ready_after_free", 64'(ir15), 64'd1);
        drain2("bp_drain");

        // Reset after 7 words written and 3 read, then a full frame.
        reset2();
        b2.out_ready = 1'b1;
        hs2 = 0;
        for (int i = 0; i < 7; i++) push2(32'(300 + i), (i == 6));
        t = 0;
        while (hs2 < 3 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("rst_three_read", 64'(hs2), 64'd3);
        #1 rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        q2.delete();
        @(negedge clk);
        chk("rst_outputs",
            {b2.in_ready, b2.out_valid, b2.out_data, b2.out_last, b2.word_sent, b2.banks_full},
            {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0});
        @(posedge clk); #1;
        hs2 = 0;
        for (int i = 0; i < 16; i++) push2(32'(400 + i), (i == 15));
        drain2("rst_frame_drain");
        chk("rst_frame_count", 64'(hs2), 64'd16);
        mon2 = 1'b0;

        // Three banks of depth 4 under random valid/ready.
        @(posedge clk); #1;
        rst3 = 1'b0;
        mon3 = 1'b1; run3 = 1'b1;
        fork
            while (run3) begin
                @(posedge clk); #1;
                b3.out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            push3(16'(i * 37 + 5), ((i % 23) == 22) || (i == 999));
        end
        t = 0;
        while (q3.size() > 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        run3 = 1'b0;
        @(negedge clk);
        chk("n3_drain", 64'(q3.size()), 64'd0);
        chk("n3_handshakes", 64'(hs3), 64'd1000);
        chk("n3_word_sent", 64'(ws3), 64'd1000);
        chk("n3_idle", {b3.banks_full, b3.in_ready}, {2'd0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/out_pingpong_buffer.md
# out_pingpong_buffer

Parametrised multi-bank output buffer between the processing core's result stream and the output interface. It generalises the two-bank, 16-deep, 32-bit output buffer to N banks of configurable width and depth. It adds an input-side ready for backpressure and a per-bank frame-length record so that a short final frame (closed by `in_last`) drains exactly its words with `out_last` on the final one. It also reports one registered pulse per word delivered downstream, which the controller uses for credit accounting.

## Interface
- `DATA_WIDTH`, 32: sample width in bits.
- `DEPTH`, 16: words per bank; power of two, ≥ 2.
- `NUM_BANKS`, 2: number of banks, ≥ 2.
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: input word present.
- `in_data`  in  DATA_WIDTH: input word.
- `in_last`  in  1: qualifies `in_valid`; the word is the last of a frame.
- `in_ready`  out  1: the buffer accepts a word this cycle (combinational).
- `out_valid`  out  1: registered output word valid.
- `out_data`  out  DATA_WIDTH: registered output word.
- `out_last`  out  1: registered; the word is the final one of a frame.
- `out_ready`  in  1: downstream accepts the word this cycle.
- `word_sent`  out  1: registered pulse, high one cycle after each `out_valid && out_ready`.
- `banks_full`  out  clog2(NUM_BANKS+1): registered count of banks that are closed and not yet fully drained.

## Operation
- Each bank has a state: EMPTY, FILLING, or FULL. It also stores `len` (1..DEPTH) and a `last` flag.
  - Storage is an internal register array with asynchronous read.
- Write side:
  - Write pointer `wb` and word counter `wcnt` (clog2(DEPTH) bits).
  - `in_ready = (state[wb] != FULL)`.
  - Accept on `in_valid && in_ready`: `mem[wb][wcnt] <= in_data`, and bank `wb` becomes FILLING.
  - If `wcnt == DEPTH-1` or `in_last`: bank `wb` becomes FULL, with `len = wcnt+1` and `last = in_last`. Then `wcnt <= 0` and `wb <= (wb+1) mod NUM_BANKS`.
  - Otherwise: `wcnt <= wcnt+1`.
- Read side:
  - Read pointer `rb` and word counter `rcnt`.
  - Pop condition: `state[rb] == FULL && (!out_valid || out_ready)`.
  - On pop: `out_data <= mem[rb][rcnt]`, `out_valid <= 1`, `out_last <= last[rb] && (rcnt == len[rb]-1)`.
  - If `rcnt == len[rb]-1`: bank `rb` becomes EMPTY, `rcnt <= 0`, `rb <= (rb+1) mod NUM_BANKS`.
  - Otherwise: `rcnt <= rcnt+1`.
  - If there is no pop and `out_ready` is high: `out_valid <= 0` and `out_last <= 0`. `out_data` holds its value.
- Rules:
  - Banks are filled and drained strictly in round-robin order.
  - A word whose `in_last` is low never sets `out_last`.
  - A full-length bank closed with `in_last` asserts `out_last` on word DEPTH-1.
- Simultaneous events:
  - A write to `wb` and a pop from `rb` in the same cycle are always legal. A bank is never both writable and readable.
  - A bank freed in cycle t is writable in cycle t+1, so `in_ready` rises at t+1.
- `banks_full` increments when a bank closes and decrements when a bank is freed. It is unchanged when both happen in the same cycle.
- Reset (including mid-frame) returns the block to its initial state:
  - All banks EMPTY; `wb`, `rb`, `wcnt`, `rcnt` = 0.
  - In-flight data is discarded.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `word_sent`=0, `banks_full`=0. `in_ready` is 1 from the first cycle after reset.
- Latency: closing write in cycle t → bank FULL at t+1 → pop at t+1 → `out_valid` high at t+2.
- Throughput: with `out_ready` held high, one word per cycle, with no bubble between banks.
- Backpressure: `out_data`/`out_last` hold while `out_valid && !out_ready`. `in_ready` drops when all banks are FULL.
- `word_sent` rises one cycle after the handshake and never lasts longer than one cycle per word.

## Test plan
- Streaming, DEPTH=16, NUM_BANKS=2, `out_ready`=1, 64 words 0..63 with `in_last` on word 63:
  - Output is 0..63 in order, with no gaps after the first word.
  - First `out_valid` comes 2 cycles after word 15 is written.
  - `out_last` is set only on 63.
- Short frame: 5 words 100..104 with `in_last` on 104:
  - Exactly 5 output words.
  - `out_last` on 104.
  - The next frame starts in the next bank at `wcnt`=0.
- Backpressure: `out_ready`=0 while 32 words are written:
  - `in_ready` falls after word 31 is accepted.
  - `banks_full`=2.
  - `out_data` holds word 0.
  - After `out_ready` rises, `in_ready` returns 1 cycle after bank 0 is freed.
- NUM_BANKS=3, random `in_valid`/`out_ready` over 1000 words:
  - Output sequence equals input sequence.
  - `word_sent` count = 1000.
  - `banks_full` never exceeds 3.
- Reset after 7 words written and 3 read:
  - All outputs at reset values the next cycle.
  - A subsequent 16-word frame is output intact from bank 0.
